// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates CPU and debug requesters onto a word-wide memory,
// turning byte/halfword accesses into whole-word reads, writes and read-modify-writes.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [2:0]  i_cpu_funct3,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  output logic        o_cpu_err,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_ready,
  output logic [3:0]  o_mem_wmem,
  output logic [4:0]  o_mem_rmem,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_store_data,
  input  logic [31:0] i_mem_load_data,
  output logic [1:0]  o_state
);

  // Handshake: a requester raises req with addr/we/funct3/wdata stable and keeps them
  // until it sees its one-cycle ready pulse; in that ready cycle it may present the next request.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RMW_MERGE = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic        r_last_dbg;
  logic        r_owner_dbg;
  logic [31:0] r_cpu_rdata, r_dbg_rdata;
  logic        r_cpu_ready, r_dbg_ready, r_cpu_err;

  logic        w_idle, w_grant_cpu, w_grant_dbg, w_cpu_bad, w_cpu_full;
  logic [31:0] w_cpu_idx, w_dbg_idx, w_merged, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_unused  = ^{i_cpu_addr[31:ADDR_WIDTH+2], i_dbg_addr[31:ADDR_WIDTH+2], i_dbg_addr[1:0]};
  assign w_cpu_idx = {{(32-ADDR_WIDTH){1'b0}}, i_cpu_addr[ADDR_WIDTH+1:2]};
  assign w_dbg_idx = {{(32-ADDR_WIDTH){1'b0}}, i_dbg_addr[ADDR_WIDTH+1:2]};

  // Round-robin tie break: the side that did not win last time gets this grant.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant_cpu = w_idle & i_cpu_req & (~i_dbg_req | r_last_dbg);
  assign w_grant_dbg = w_idle & i_dbg_req & (~i_cpu_req | ~r_last_dbg);
  assign w_cpu_full  = i_cpu_we & (i_cpu_funct3 == 3'b010);

  always_comb begin
    w_cpu_bad = 1'b0;
    case (i_cpu_funct3)
      3'b000:         w_cpu_bad = 1'b0;
      3'b001:         w_cpu_bad = i_cpu_addr[0];
      3'b010:         w_cpu_bad = (i_cpu_addr[1:0] != 2'b00);
      3'b100, 3'b101: w_cpu_bad = i_cpu_we;
      default:        w_cpu_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (i_cpu_addr[1:0])
      2'd0: w_byte = i_mem_load_data[7:0];
      2'd1: w_byte = i_mem_load_data[15:8];
      2'd2: w_byte = i_mem_load_data[23:16];
      2'd3: w_byte = i_mem_load_data[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_cpu_addr[1] ? i_mem_load_data[31:16] : i_mem_load_data[15:0];
    w_ext  = i_mem_load_data;
    case (i_cpu_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = i_mem_load_data;
    endcase
  end

  always_comb begin
    w_merged = i_mem_load_data;
    if (i_cpu_funct3[0]) begin
      if (i_cpu_addr[1]) w_merged[31:16] = i_cpu_wdata[15:0];
      else               w_merged[15:0]  = i_cpu_wdata[15:0];
    end else begin
      case (i_cpu_addr[1:0])
        2'd0: w_merged[7:0]   = i_cpu_wdata[7:0];
        2'd1: w_merged[15:8]  = i_cpu_wdata[7:0];
        2'd2: w_merged[23:16] = i_cpu_wdata[7:0];
        2'd3: w_merged[31:24] = i_cpu_wdata[7:0];
        default: w_merged = i_mem_load_data;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    o_mem_wmem       = 4'b0000;
    o_mem_rmem       = 5'b00000;
    o_mem_addr       = 32'h0;
    o_mem_store_data = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_cpu && !w_cpu_bad) begin
          o_mem_addr = w_cpu_idx;
          if (w_cpu_full) begin
            o_mem_wmem       = 4'b1111;
            o_mem_store_data = i_cpu_wdata;
          end else begin
            o_mem_rmem = 5'b00001;
            w_next     = i_cpu_we ? S_RMW_MERGE : S_LOAD_WAIT;
          end
        end else if (w_grant_dbg) begin
          o_mem_addr = w_dbg_idx;
          if (i_dbg_we) begin
            o_mem_wmem       = 4'b1111;
            o_mem_store_data = i_dbg_wdata;
          end else begin
            o_mem_rmem = 5'b00001;
            w_next     = S_LOAD_WAIT;
          end
        end
      end
      S_LOAD_WAIT: w_next = S_IDLE;
      S_RMW_MERGE: begin
        o_mem_addr       = w_cpu_idx;
        o_mem_wmem       = 4'b1111;
        o_mem_store_data = w_merged;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset aborts whatever is in flight before it can reach the memory.
    if (rst) begin
      w_next           = S_IDLE;
      o_mem_wmem       = 4'b0000;
      o_mem_rmem       = 5'b00000;
      o_mem_addr       = 32'h0;
      o_mem_store_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_dbg  <= 1'b1;
      r_owner_dbg <= 1'b0;
      r_cpu_rdata <= 32'h0;
      r_dbg_rdata <= 32'h0;
      r_cpu_ready <= 1'b0;
      r_dbg_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_ready <= 1'b0;
      r_dbg_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      if (w_grant_cpu) begin
        r_last_dbg  <= 1'b0;
        r_owner_dbg <= 1'b0;
        if (w_cpu_bad) begin
          r_cpu_ready <= 1'b1;
          r_cpu_err   <= 1'b1;
        end else if (w_cpu_full) begin
          r_cpu_ready <= 1'b1;
        end
      end else if (w_grant_dbg) begin
        r_last_dbg  <= 1'b1;
        r_owner_dbg <= 1'b1;
        if (i_dbg_we) r_dbg_ready <= 1'b1;
      end
      if (r_state == S_LOAD_WAIT) begin
        if (r_owner_dbg) begin
          r_dbg_rdata <= i_mem_load_data;
          r_dbg_ready <= 1'b1;
        end else begin
          r_cpu_rdata <= w_ext;
          r_cpu_ready <= 1'b1;
        end
      end
      if (r_state == S_RMW_MERGE) r_cpu_ready <= 1'b1;
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_cpu_err   = r_cpu_err;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_dbg_ready = r_dbg_ready;
  assign o_state     = r_state;

endmodule
